// File: rtl/coord_bus_writer.sv
// Bus initiator that forwards buffered {X,Y} mouse-region samples to the 7-segment
// peripheral as an X/Y write pair, optionally dropping repeats of the last pair written.
module coord_bus_writer #(
    parameter logic [7:0] BASE_ADDR = 8'hD0,
    parameter logic       SKIP_SAME = 1'b1
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] COORD_X,
    input  logic [7:0] COORD_Y,
    input  logic       COORD_VALID,
    output logic       COORD_READY,
    output logic       BUS_REQ,
    input  logic       BUS_GNT,
    output logic [7:0] BUS_ADDR,
    output logic [7:0] BUS_DATA,
    output logic       BUS_WE,
    output logic [7:0] WRITE_COUNT,
    output logic       BUSY
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_WR_X = 3'd2,
        ST_WR_Y = 3'd3,
        ST_REL  = 3'd4
    } state_t;

    localparam logic [7:0] Y_ADDR = BASE_ADDR + 8'd1;

    state_t      state_r;
    state_t      state_next_s;
    logic [15:0] fifo_mem_r [2];
    logic        wr_ptr_r;
    logic        rd_ptr_r;
    logic [1:0]  fifo_cnt_r;
    logic [1:0]  fifo_cnt_next_s;
    logic        ready_r;
    logic [15:0] hold_r;
    logic [15:0] hold_next_s;
    logic [15:0] last_r;
    logic [15:0] head_s;
    logic        push_s;
    logic        pop_s;
    logic        skip_s;
    logic        done_s;
    logic        bus_req_r;
    logic        bus_we_r;
    logic [7:0]  bus_addr_r;
    logic [7:0]  bus_data_r;
    logic [7:0]  write_count_r;
    logic        busy_r;

    // Handshake, pop and duplicate-detection decode
    always_comb begin
        head_s = fifo_mem_r[rd_ptr_r];
        push_s = COORD_VALID && ready_r;
        pop_s  = (state_r == ST_IDLE) && (fifo_cnt_r != 2'd0);
        skip_s = SKIP_SAME && (head_s == last_r);
        done_s = (state_r == ST_WR_Y) && BUS_GNT;
        if (pop_s) begin
            hold_next_s = head_s;
        end else begin
            hold_next_s = hold_r;
        end
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_next_s = fifo_cnt_r + 2'd1;
            2'b01:   fifo_cnt_next_s = fifo_cnt_r - 2'd1;
            default: fifo_cnt_next_s = fifo_cnt_r;
        endcase
    end

    // Next-state logic; a lost grant in either write phase restarts from X
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (pop_s && !skip_s) begin
                    state_next_s = ST_REQ;
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_REQ:  state_next_s = BUS_GNT ? ST_WR_X : ST_REQ;
            ST_WR_X: state_next_s = BUS_GNT ? ST_WR_Y : ST_REQ;
            ST_WR_Y: state_next_s = BUS_GNT ? ST_REL : ST_REQ;
            ST_REL:  state_next_s = ST_IDLE;
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Two-entry sample FIFO and its registered not-full flag
    always_ff @(posedge CLK) begin
        if (RESET) begin
            fifo_mem_r[0] <= 16'h0000;
            fifo_mem_r[1] <= 16'h0000;
            wr_ptr_r      <= 1'b0;
            rd_ptr_r      <= 1'b0;
            fifo_cnt_r    <= 2'd0;
            ready_r       <= 1'b1;
        end else begin
            if (push_s) begin
                fifo_mem_r[wr_ptr_r] <= {COORD_X, COORD_Y};
                wr_ptr_r             <= ~wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            fifo_cnt_r <= fifo_cnt_next_s;
            ready_r    <= (fifo_cnt_next_s != 2'd2);
        end
    end

    // Controller state plus bus outputs registered from the state being entered
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_r       <= ST_IDLE;
            hold_r        <= 16'h0000;
            last_r        <= 16'h0000;
            write_count_r <= 8'd0;
            bus_req_r     <= 1'b0;
            bus_we_r      <= 1'b0;
            bus_addr_r    <= 8'd0;
            bus_data_r    <= 8'd0;
            busy_r        <= 1'b0;
        end else begin
            state_r <= state_next_s;
            hold_r  <= hold_next_s;
            if (done_s) begin
                last_r        <= hold_r;
                write_count_r <= write_count_r + 8'd1;
            end
            bus_req_r <= (state_next_s == ST_REQ) || (state_next_s == ST_WR_X)
                         || (state_next_s == ST_WR_Y);
            bus_we_r  <= (state_next_s == ST_WR_X) || (state_next_s == ST_WR_Y);
            case (state_next_s)
                ST_WR_X: begin
                    bus_addr_r <= BASE_ADDR;
                    bus_data_r <= hold_next_s[15:8];
                end
                ST_WR_Y: begin
                    bus_addr_r <= Y_ADDR;
                    bus_data_r <= hold_next_s[7:0];
                end
                default: begin
                    bus_addr_r <= 8'd0;
                    bus_data_r <= 8'd0;
                end
            endcase
            busy_r <= (state_next_s != ST_IDLE) || (fifo_cnt_next_s != 2'd0);
        end
    end

    assign COORD_READY = ready_r;
    assign BUS_REQ     = bus_req_r;
    assign BUS_WE      = bus_we_r;
    assign BUS_ADDR    = bus_addr_r;
    assign BUS_DATA    = bus_data_r;
    assign WRITE_COUNT = write_count_r;
    assign BUSY        = busy_r;

endmodule

// File: tb/tb_coord_bus_writer.sv
// Bench for coord_bus_writer: directed scenarios plus a random run scored against a
// queue model of which samples must reach the bus as completed X/Y pairs.
module tb_coord_bus_writer;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] COORD_X;
    logic [7:0] COORD_Y;
    logic       COORD_VALID;
    logic       COORD_READY;
    logic       BUS_REQ;
    logic       BUS_GNT;
    logic [7:0] BUS_ADDR;
    logic [7:0] BUS_DATA;
    logic       BUS_WE;
    logic [7:0] WRITE_COUNT;
    logic       BUSY;

    int          checks = 0;
    int          errors = 0;
    bit          rand_gnt = 1'b0;
    logic [7:0]  x_seen = 8'h00;
    logic [15:0] obs_q[$];
    logic [15:0] exp_q[$];

    coord_bus_writer #(.BASE_ADDR(8'hD0), .SKIP_SAME(1'b1)) dut (
        .CLK(CLK), .RESET(RESET), .COORD_X(COORD_X), .COORD_Y(COORD_Y),
        .COORD_VALID(COORD_VALID), .COORD_READY(COORD_READY),
        .BUS_REQ(BUS_REQ), .BUS_GNT(BUS_GNT), .BUS_ADDR(BUS_ADDR),
        .BUS_DATA(BUS_DATA), .BUS_WE(BUS_WE), .WRITE_COUNT(WRITE_COUNT), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Bus monitor: a pair is complete when the Y byte is strobed while granted
    always @(negedge CLK) begin
        if (BUS_WE === 1'b1) begin
            if (BUS_ADDR == 8'hD0) x_seen = BUS_DATA;
            else if (BUS_ADDR == 8'hD1) begin
                if (BUS_GNT) obs_q.push_back({x_seen, BUS_DATA});
            end else chk("bus_addr", {24'd0, BUS_ADDR}, 32'hD0);
        end else begin
            chk("idle_bus", {16'd0, BUS_ADDR, BUS_DATA}, 32'd0);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
        if (rand_gnt) BUS_GNT = ($urandom_range(0, 3) != 0);
    endtask

    task automatic push(input logic [7:0] x, input logic [7:0] y);
        bit acc = 1'b0;
        COORD_X = x;
        COORD_Y = y;
        COORD_VALID = 1'b1;
        for (int n = 0; n < 400 && !acc; n++) begin
            @(negedge CLK);
            acc = COORD_READY;
            step();
        end
        COORD_VALID = 1'b0;
        if (!acc) chk("push_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        obs_q.delete();
    endtask

    task automatic drain();
        bit idle = 1'b0;
        for (int n = 0; n < 300 && !idle; n++) begin
            @(negedge CLK);
            idle = !BUSY;
            if (!idle) step();
        end
        chk("drain_idle", {31'd0, idle}, 32'd1);
        step();
    endtask

    initial begin
        int          sz;
        logic [7:0]  rx;
        logic [7:0]  ry;
        logic [15:0] last;
        RESET = 1'b1; COORD_X = 8'h00; COORD_Y = 8'h00; COORD_VALID = 1'b0; BUS_GNT = 1'b0;
        step(); step();
        RESET = 1'b0;
        obs_q.delete();

        // Reset state
        @(negedge CLK);
        chk("rst_outs", {BUS_REQ, BUS_WE, BUS_ADDR, BUS_DATA, BUSY}, 32'd0);
        chk("rst_ready", {31'd0, COORD_READY}, 32'd1);
        chk("rst_count", {24'd0, WRITE_COUNT}, 32'd0);
        step();

        // Single sample, grant tied high: cycle-accurate latency
        BUS_GNT = 1'b1;
        push(8'h35, 8'h28);
        @(negedge CLK); chk("lat_k0", {BUSY, BUS_REQ}, 32'h2);
        step(); @(negedge CLK); chk("lat_req", {BUS_REQ, BUS_WE}, 32'h2);
        step(); @(negedge CLK); chk("lat_wrx", {BUS_WE, BUS_ADDR, BUS_DATA}, 32'h1D035);
        step(); @(negedge CLK); chk("lat_wry", {BUS_WE, BUS_ADDR, BUS_DATA}, 32'h1D128);
        step(); @(negedge CLK);
        chk("lat_rel", {BUS_REQ, BUS_WE, BUS_ADDR, BUS_DATA}, 32'd0);
        chk("lat_count", {24'd0, WRITE_COUNT}, 32'd1);
        chk("lat_rel_busy", {31'd0, BUSY}, 32'd1);
        step(); @(negedge CLK); chk("lat_idle_busy", {31'd0, BUSY}, 32'd0);
        chk("lat_pairs", obs_q.size(), 32'd1);
        if (obs_q.size() > 0) chk("lat_pair0", {16'd0, obs_q[0]}, 32'h3528);
        step();

        // Repeat of the last written pair is discarded
        push(8'h35, 8'h28);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLK); chk("skip_noreq", {31'd0, BUS_REQ}, 32'd0); step();
        end
        chk("skip_count", {24'd0, WRITE_COUNT}, 32'd1);
        chk("skip_pairs", obs_q.size(), 32'd1);

        // (0,0) matches the reset value of the last-written register
        do_reset();
        push(8'h00, 8'h00);
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK); chk("zero_noreq", {31'd0, BUS_REQ}, 32'd0); step();
        end
        chk("zero_count", {24'd0, WRITE_COUNT}, 32'd0);

        // Three samples with no grant fill the FIFO; a fourth is held off
        do_reset();
        BUS_GNT = 1'b0;
        push(8'h11, 8'h22); push(8'h33, 8'h44); push(8'h55, 8'h66);
        COORD_X = 8'h77; COORD_Y = 8'h88; COORD_VALID = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge CLK); chk("full_ready", {31'd0, COORD_READY}, 32'd0); step();
        end
        COORD_VALID = 1'b0;
        BUS_GNT = 1'b1;
        drain();
        chk("fill_pairs", obs_q.size(), 32'd3);
        if (obs_q.size() == 3) begin
            chk("fill_p0", {16'd0, obs_q[0]}, 32'h1122);
            chk("fill_p1", {16'd0, obs_q[1]}, 32'h3344);
            chk("fill_p2", {16'd0, obs_q[2]}, 32'h5566);
        end
        chk("fill_count", {24'd0, WRITE_COUNT}, 32'd3);

        // Grant lost during the Y write: whole pair is rewritten once
        do_reset();
        BUS_GNT = 1'b1;
        push(8'h6B, 8'h50);
        step(); step(); step();
        BUS_GNT = 1'b0;
        @(negedge CLK); chk("lost_wry", {BUS_WE, BUS_ADDR, BUS_DATA}, 32'h1D150);
        step(); @(negedge CLK);
        chk("lost_req", {BUS_REQ, BUS_WE}, 32'h2);
        chk("lost_count0", {24'd0, WRITE_COUNT}, 32'd0);
        BUS_GNT = 1'b1;
        step(); @(negedge CLK); chk("lost_rwx", {BUS_WE, BUS_ADDR, BUS_DATA}, 32'h1D06B);
        step(); @(negedge CLK); chk("lost_rwy", {BUS_WE, BUS_ADDR, BUS_DATA}, 32'h1D150);
        step(); @(negedge CLK); chk("lost_count1", {24'd0, WRITE_COUNT}, 32'd1);
        chk("lost_pairs", obs_q.size(), 32'd1);
        if (obs_q.size() > 0) chk("lost_pair0", {16'd0, obs_q[0]}, 32'h6B50);
        step();

        // Reset while writing X abandons the sample
        push(8'hAA, 8'hBB);
        step(); step();
        @(negedge CLK); chk("rx_wrx", {BUS_WE, BUS_ADDR, BUS_DATA}, 32'h1D0AA);
        sz = obs_q.size();
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        @(negedge CLK);
        chk("rx_bus", {BUS_REQ, BUS_WE, BUS_ADDR, BUS_DATA, BUSY}, 32'd0);
        chk("rx_ready", {31'd0, COORD_READY}, 32'd1);
        chk("rx_count", {24'd0, WRITE_COUNT}, 32'd0);
        for (int i = 0; i < 10; i++) step();
        chk("rx_nowrite", obs_q.size(), sz);
        chk("rx_count_hold", {24'd0, WRITE_COUNT}, 32'd0);

        // 256 distinct pairs wrap the completion counter
        do_reset();
        for (int i = 0; i < 256; i++) begin
            rx = i[7:0];
            ry = rx + 8'd1;
            push(rx, ry);
        end
        drain();
        chk("wrap_count", {24'd0, WRITE_COUNT}, 32'd0);
        chk("wrap_pairs", obs_q.size(), 32'd256);
        if (obs_q.size() == 256) chk("wrap_last", {16'd0, obs_q[255]}, 32'hFF00);

        // Random samples and random grant against the queue model
        do_reset();
        exp_q.delete();
        last = 16'h0000;
        rand_gnt = 1'b1;
        for (int n = 0; n < 400; n++) begin
            rx = 8'($urandom_range(0, 3));
            ry = 8'($urandom_range(0, 3));
            repeat ($urandom_range(0, 2)) step();
            push(rx, ry);
            if ({rx, ry} != last) begin
                exp_q.push_back({rx, ry});
                last = {rx, ry};
            end
        end
        rand_gnt = 1'b0;
        BUS_GNT = 1'b1;
        drain();
        chk("rand_len", obs_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
            chk($sformatf("rand_pair%0d", i), {16'd0, obs_q[i]}, {16'd0, exp_q[i]});
        sz = exp_q.size();
        chk("rand_count", {24'd0, WRITE_COUNT}, {24'd0, sz[7:0]});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
